// File: rtl/vrlp_eth_pkg.sv
// vrlp_eth_pkg: constants shared by the VRLP Ethernet framer and deframer.
// Holds the header parser state encoding, protocol field values and header sizes.
package vrlp_eth_pkg;

    // Header parser states: one state per header word, then payload or drop.
    localparam logic [2:0] ST_H1      = 3'd0;
    localparam logic [2:0] ST_H2      = 3'd1;
    localparam logic [2:0] ST_H3      = 3'd2;
    localparam logic [2:0] ST_H4      = 3'd3;
    localparam logic [2:0] ST_H5      = 3'd4;
    localparam logic [2:0] ST_H6      = 3'd5;
    localparam logic [2:0] ST_PAYLOAD = 3'd6;
    localparam logic [2:0] ST_DROP    = 3'd7;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] IP_HDR_BYTES  = 16'd20;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam int          HDR_WORDS     = 6;

    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vrlp_eth_hdr_check.sv
// vrlp_eth_hdr_check: combinational per-word header match.
// Given the parser state and the current 64-bit word, reports whether the
// fields carried by that word agree with the local configuration.
module vrlp_eth_hdr_check
    import vrlp_eth_pkg::*;
(
    input  logic [2:0]  state_i,
    input  logic [63:0] word_i,
    input  logic [15:0] mac_hi_i,
    input  logic [31:0] mac_lo_i,
    input  logic [31:0] ip_i,
    input  logic [15:0] port_i,
    input  logic [15:0] ip_len_i,
    output logic        pass_o
);

    // Select the field checks that belong to the word being parsed.
    always_comb begin
        pass_o = 1'b0;
        case (state_i)
            // Broadcast destination MAC is always accepted.
            ST_H1: pass_o = (word_i[15:0] == mac_hi_i) || (word_i[15:0] == 16'hFFFF);
            ST_H2: pass_o = (word_i[63:32] == mac_lo_i) || (word_i[63:32] == 32'hFFFF_FFFF);
            ST_H3: pass_o = (word_i[47:32] == ETH_TYPE_IPV4) && (word_i[31:24] == IPV4_VER_IHL);
            // Reject any fragment: MF set or non-zero fragment offset.
            ST_H4: pass_o = (word_i[23:16] == IP_PROTO_UDP) && !word_i[45] && (word_i[44:32] == 13'd0);
            ST_H5: pass_o = (word_i[31:0] == ip_i);
            ST_H6: pass_o = (word_i[47:32] == port_i) && (word_i[31:16] == (ip_len_i - IP_HDR_BYTES));
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vrlp_eth_deframer.sv
// vrlp_eth_deframer: strips and checks Ethernet/IPv4/UDP headers on the MAC RX
// stream and forwards matching VRLP payload with zero latency.
// Optional build macro: VRLP_ETH_DEFRAMER_STATS_EN enables the drop and
// length-error counters and the payload byte counter.
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// valid never depends on ready; in PAYLOAD in_tready is out_tready, so the
// input beat and the output beat are the same transfer.
module vrlp_eth_deframer
    import vrlp_eth_pkg::*;
#(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] in_tdata,
    input  logic [3:0]  in_tuser,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [63:0] out_tdata,
    output logic [3:0]  out_tuser,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [31:0] drop_cnt,
    output logic [31:0] len_err_cnt,
    output logic [2:0]  dbg_state_o
);

    logic [15:0] mac_hi_q;
    logic [31:0] mac_lo_q;
    logic [31:0] ip_q;
    logic [15:0] port_q;

    logic [2:0]  state_q, state_d;
    logic        ok_q, ok_d;
    logic [15:0] ip_len_q, ip_len_d;
    logic        hdr_pass;
    logic        beat;
    logic        last_beat;

    assign beat        = in_tvalid & in_tready;
    assign last_beat   = beat & in_tlast;
    assign dbg_state_o = state_q;

    vrlp_eth_hdr_check u_hdr_check (
        .state_i  (state_q),
        .word_i   (in_tdata),
        .mac_hi_i (mac_hi_q),
        .mac_lo_i (mac_lo_q),
        .ip_i     (ip_q),
        .port_i   (port_q),
        .ip_len_i (ip_len_q),
        .pass_o   (hdr_pass)
    );

    // Settings registers: survive clear, only reset returns them to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_hi_q <= 16'd0;
            mac_lo_q <= 32'd0;
            ip_q     <= 32'd0;
            port_q   <= 16'd0;
        end else if (set_stb) begin
            if (set_addr == BASE)         mac_hi_q <= set_data[15:0];
            if (set_addr == BASE + 8'd1)  mac_lo_q <= set_data;
            if (set_addr == BASE + 8'd2)  ip_q     <= set_data;
            if (set_addr == BASE + 8'd3)  port_q   <= set_data[15:0];
        end
    end

    // FSM state register; reset and clear abort any frame in progress.
    always_ff @(posedge clk) begin
        if (reset || clear) state_q <= ST_H1;
        else                state_q <= state_d;
    end

    // FSM next state: one header word per accepted beat, tlast in the header is a runt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_H1, ST_H2, ST_H3, ST_H4, ST_H5: begin
                if (beat) state_d = in_tlast ? ST_H1 : state_q + 3'd1;
            end
            ST_H6: begin
                if (beat) begin
                    if (in_tlast)              state_d = ST_H1;
                    else if (ok_q && hdr_pass) state_d = ST_PAYLOAD;
                    else                       state_d = ST_DROP;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (last_beat) state_d = ST_H1;
            end
            default: state_d = ST_H1;
        endcase
    end

    // FSM outputs: payload passes straight through, everything else is swallowed.
    always_comb begin
        in_tready  = 1'b1;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        out_tuser  = 4'd0;
        out_tdata  = in_tdata;
        if (state_q == ST_PAYLOAD) begin
            in_tready  = out_tready;
            out_tvalid = in_tvalid;
            out_tlast  = in_tlast;
            out_tuser  = in_tuser;
        end
    end

    // Header accumulation: sticky match flag restarts on the first word, ip_len from W3.
    always_comb begin
        ok_d     = ok_q;
        ip_len_d = ip_len_q;
        if (beat) begin
            case (state_q)
                ST_H1:               ok_d = hdr_pass;
                ST_H2, ST_H4, ST_H5: ok_d = ok_q & hdr_pass;
                ST_H3: begin
                    ok_d     = ok_q & hdr_pass;
                    ip_len_d = in_tdata[15:0];
                end
                default: ok_d = ok_q;
            endcase
        end
    end

    // Header accumulation registers.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ok_q     <= 1'b0;
            ip_len_q <= 16'd0;
        end else begin
            ok_q     <= ok_d;
            ip_len_q <= ip_len_d;
        end
    end

`ifdef VRLP_ETH_DEFRAMER_STATS_EN
    logic [15:0] udp_len_q, udp_len_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] last_bytes, total_bytes;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] len_err_q, len_err_d;
    logic        drop_evt, len_err_evt;

    // Statistics next state: byte count over the payload and saturating event counters.
    always_comb begin
        udp_len_d   = udp_len_q;
        byte_cnt_d  = byte_cnt_q;
        last_bytes  = (in_tuser == 4'd0) ? 16'd8 : {12'd0, in_tuser};
        total_bytes = byte_cnt_q + last_bytes;
        drop_evt    = last_beat && ((state_q <= ST_H6) || (state_q == ST_DROP));
        len_err_evt = last_beat && (state_q == ST_PAYLOAD) &&
                      (total_bytes != (udp_len_q - UDP_HDR_BYTES));
        if (beat && (state_q == ST_H6)) begin
            udp_len_d  = in_tdata[31:16];
            byte_cnt_d = 16'd0;
        end else if (beat && (state_q == ST_PAYLOAD) && !in_tlast) begin
            byte_cnt_d = byte_cnt_q + 16'd8;
        end
        drop_cnt_d = drop_evt    ? sat_inc(drop_cnt_q) : drop_cnt_q;
        len_err_d  = len_err_evt ? sat_inc(len_err_q)  : len_err_q;
    end

    // Statistics registers; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            udp_len_q  <= 16'd0;
            byte_cnt_q <= 16'd0;
            drop_cnt_q <= 32'd0;
            len_err_q  <= 32'd0;
        end else begin
            udp_len_q  <= udp_len_d;
            byte_cnt_q <= byte_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign drop_cnt    = drop_cnt_q;
    assign len_err_cnt = len_err_q;
`else
    assign drop_cnt    = 32'd0;
    assign len_err_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vrlp_eth_deframer.sv
// tb_vrlp_eth_deframer: table of hand-checked frames, multi-cycle corner
// sequences (back-to-back, output backpressure, clear), then randomized
// frames checked against a field-level model of the acceptance rules.
`timescale 1ns/1ps
module tb_vrlp_eth_deframer;
    import vrlp_eth_pkg::*;

    localparam logic [7:0]  BASE_ADDR = 8'h10;
    localparam logic [15:0] L_MAC_HI  = 16'h0080;
    localparam logic [31:0] L_MAC_LO  = 32'h2F00_0001;
    localparam logic [31:0] L_IP      = 32'hC0A8_0A02;
    localparam logic [15:0] L_PORT    = 16'hC001;
`ifdef VRLP_ETH_DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, reset, clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [63:0] in_tdata;
    logic [3:0]  in_tuser;
    logic        in_tlast, in_tvalid, in_tready;
    logic [63:0] out_tdata;
    logic [3:0]  out_tuser;
    logic        out_tlast, out_tvalid, out_tready;
    logic [31:0] drop_cnt, len_err_cnt;
    logic [2:0]  dbg_state_o;

    vrlp_eth_deframer #(.BASE(BASE_ADDR)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .in_tdata    (in_tdata),
        .in_tuser    (in_tuser),
        .in_tlast    (in_tlast),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .out_tdata   (out_tdata),
        .out_tuser   (out_tuser),
        .out_tlast   (out_tlast),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .drop_cnt    (drop_cnt),
        .len_err_cnt (len_err_cnt),
        .dbg_state_o (dbg_state_o)
    );

    typedef struct {
        logic [47:0] dst_mac;
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [15:0] flags_frag;
        logic [7:0]  proto;
        logic [31:0] ip_dst;
        logic [15:0] udp_dst;
        logic [15:0] ip_len;
        logic [15:0] udp_len;
        int          n_pay;
        logic [3:0]  last_user;
        int          runt_at;
    } frame_t;

    typedef struct {
        frame_t f;
        bit     fwd;
        bit     lerr;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          beats_sent = 0;
    int          exp_drop = 0;
    int          exp_lerr = 0;
    int          rdy_mode = 0;
    logic [68:0] exp_q[$];
    logic [68:0] pay_q[$];
    beat_t       tx_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output backpressure: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_tready = ~out_tready;
                2:       out_tready = 1'($urandom_range(0, 1));
                default: out_tready = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every delivered output beat must be the next expected payload beat.
    always @(negedge clk) begin
        if (!reset && out_tvalid) begin
            check("in_tready_mirror", 72'(in_tready), 72'(out_tready));
            if (out_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h required no output", out_tdata);
                end else begin
                    check("payload_beat", 72'({out_tdata, out_tuser, out_tlast}), 72'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- frame construction and model ----------------
    function automatic frame_t good_frame(input int n_pay, input logic [3:0] lu);
        frame_t f;
        int     bytes;
        bytes        = 8 * (n_pay - 1) + ((lu == 4'd0) ? 8 : int'(lu));
        f.dst_mac    = {L_MAC_HI, L_MAC_LO};
        f.ethertype  = 16'h0800;
        f.ver_ihl    = 8'h45;
        f.flags_frag = 16'h4000;
        f.proto      = 8'h11;
        f.ip_dst     = L_IP;
        f.udp_dst    = L_PORT;
        f.udp_len    = 16'(bytes + 8);
        f.ip_len     = 16'(bytes + 28);
        f.n_pay      = n_pay;
        f.last_user  = lu;
        f.runt_at    = 0;
        return f;
    endfunction

    function automatic bit model_fwd(input frame_t f);
        bit mac_ok;
        if (f.runt_at != 0) return 1'b0;
        mac_ok = (f.dst_mac[47:32] == L_MAC_HI || f.dst_mac[47:32] == 16'hFFFF) &&
                 (f.dst_mac[31:0] == L_MAC_LO || f.dst_mac[31:0] == 32'hFFFF_FFFF);
        return mac_ok && f.ethertype == 16'h0800 && f.ver_ihl == 8'h45 && f.proto == 8'h11 &&
               !f.flags_frag[13] && f.flags_frag[12:0] == 13'd0 && f.ip_dst == L_IP &&
               f.udp_dst == L_PORT && int'(f.udp_len) == int'(f.ip_len) - 20;
    endfunction

    function automatic bit model_lerr(input frame_t f);
        int bytes;
        bytes = 8 * (f.n_pay - 1) + ((f.last_user == 4'd0) ? 8 : int'(f.last_user));
        return model_fwd(f) && (bytes != int'(f.udp_len) - 8);
    endfunction

    task automatic build(input frame_t f);
        beat_t       b;
        logic [47:0] src;
        logic [63:0] w[6];
        int          nh;
        src  = {16'($urandom()), $urandom()};
        w[0] = {$urandom(), 16'($urandom()), f.dst_mac[47:32]};
        w[1] = {f.dst_mac[31:0], src[47:16]};
        w[2] = {src[15:0], f.ethertype, f.ver_ihl, 8'h00, f.ip_len};
        w[3] = {16'($urandom()), f.flags_frag, 8'd64, f.proto, 16'h0000};
        w[4] = {32'hC0A8_0A01, f.ip_dst};
        w[5] = {16'($urandom()), f.udp_dst, f.udp_len, 16'h0000};
        tx_q.delete();
        pay_q.delete();
        nh = (f.runt_at != 0) ? f.runt_at : 6;
        for (int i = 0; i < nh; i++) begin
            b.d = w[i];
            b.u = 4'd0;
            b.l = (f.runt_at != 0) && (i == nh - 1);
            tx_q.push_back(b);
        end
        if (f.runt_at == 0) begin
            for (int i = 0; i < f.n_pay; i++) begin
                b.d = {$urandom(), $urandom()};
                b.l = (i == f.n_pay - 1);
                b.u = b.l ? f.last_user : 4'($urandom_range(0, 15));
                tx_q.push_back(b);
                pay_q.push_back({b.d, b.u, b.l});
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic send_beat(input beat_t b);
        int waitc;
        waitc     = 0;
        in_tvalid = 1'b1;
        in_tdata  = b.d;
        in_tuser  = b.u;
        in_tlast  = b.l;
        @(negedge clk);
        while (!in_tready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_tready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: in_tready 0 for 100 cycles, required 1");
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 4'd0;
        beats_sent++;
    endtask

    task automatic check_idle();
        check("drop_cnt", 72'(drop_cnt), STATS ? 72'(exp_drop) : 72'd0);
        check("len_err_cnt", 72'(len_err_cnt), STATS ? 72'(exp_lerr) : 72'd0);
        check("state_idle", 72'(dbg_state_o), 72'(ST_H1));
        check("exp_q_drained", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic send_frame(input frame_t f, input bit fwd, input bit lerr, input int gap_pct);
        build(f);
        if (fwd) foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        foreach (tx_q[i]) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            send_beat(tx_q[i]);
        end
        if (!fwd) exp_drop++;
        if (lerr) exp_lerr++;
        check_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t   vecs[13];
        frame_t f;
        int     c0, b0, k;

        reset = 1'b1; clear = 1'b0;
        set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        in_tvalid = 1'b0; in_tdata = 64'd0; in_tuser = 4'd0; in_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_tready", 72'(in_tready), 72'd1);
        check("rst_out_tvalid", 72'(out_tvalid), 72'd0);
        check("rst_out_tlast", 72'(out_tlast), 72'd0);
        check("rst_out_tuser", 72'(out_tuser), 72'd0);
        check("rst_drop_cnt", 72'(drop_cnt), 72'd0);
        check("rst_len_err_cnt", 72'(len_err_cnt), 72'd0);
        check("rst_state", 72'(dbg_state_o), 72'(ST_H1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_reg(BASE_ADDR,        {16'd0, L_MAC_HI});
        set_reg(BASE_ADDR + 8'd1, L_MAC_LO);
        set_reg(BASE_ADDR + 8'd2, L_IP);
        set_reg(BASE_ADDR + 8'd3, {16'd0, L_PORT});

        // Table: frame variants with hand-derived forward / length-error outcomes.
        for (int i = 0; i < 13; i++) begin
            vecs[i].f    = good_frame(5, 4'd4);
            vecs[i].fwd  = 1'b0;
            vecs[i].lerr = 1'b0;
        end
        vecs[0].fwd = 1'b1;
        vecs[1].f.udp_dst = 16'hC002;
        vecs[2].fwd = 1'b1;
        vecs[3].f.dst_mac = 48'hFFFF_FFFF_FFFF;
        vecs[3].fwd = 1'b1;
        vecs[4].f.flags_frag = 16'h2000;
        vecs[5].f.ethertype = 16'h86DD;
        vecs[6].f.runt_at = 4;
        vecs[7].f = good_frame(1, 4'd1);
        vecs[7].fwd = 1'b1;
        vecs[8].f = good_frame(6, 4'd0);
        vecs[8].f.udp_len = 16'd44;
        vecs[8].f.ip_len = 16'd64;
        vecs[8].fwd = 1'b1;
        vecs[8].lerr = 1'b1;
        vecs[9].f.flags_frag = 16'h0001;
        vecs[10].f.ip_dst = 32'hC0A8_0A03;
        vecs[11].f.ip_len = 16'd65;
        vecs[12].f.ver_ihl = 8'h46;

        c0 = cyc;
        b0 = beats_sent;
        for (int i = 0; i < 13; i++) send_frame(vecs[i].f, vecs[i].fwd, vecs[i].lerr, 0);
        check("no_gap_cycles", 72'(cyc - c0), 72'(beats_sent - b0));

        // Output backpressure toggling every cycle over a long payload.
        rdy_mode = 1;
        send_frame(good_frame(20, 4'd6), 1'b1, 1'b0, 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Clear on the same cycle as a drop-counting last beat: clear wins.
        f = good_frame(3, 4'd8);
        f.udp_dst = 16'hC003;
        build(f);
        for (int i = 0; i < tx_q.size() - 1; i++) send_beat(tx_q[i]);
        clear = 1'b1;
        send_beat(tx_q[tx_q.size() - 1]);
        clear = 1'b0;
        exp_drop = 0;
        exp_lerr = 0;
        check_idle();

        // Clear mid-header: the rest of the frame is reparsed and ends as a runt.
        build(good_frame(1, 4'd8));
        for (int i = 0; i < 3; i++) send_beat(tx_q[i]);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_state", 72'(dbg_state_o), 72'(ST_H1));
        check("clear_drop_cnt", 72'(drop_cnt), 72'd0);
        for (int i = 3; i < tx_q.size(); i++) send_beat(tx_q[i]);
        exp_drop++;
        check_idle();

        // Randomized frames against the field-level model.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            f = good_frame(int'($urandom_range(1, 8)), 4'($urandom_range(0, 8)));
            k = int'($urandom_range(0, 12));
            case (k)
                0:  f.dst_mac[$urandom_range(0, 47)] = ~f.dst_mac[$urandom_range(0, 47)];
                1:  f.dst_mac = 48'hFFFF_FFFF_FFFF;
                2:  f.ethertype = 16'h86DD;
                3:  f.flags_frag[13] = 1'b1;
                4:  f.flags_frag[12:0] = 13'($urandom_range(1, 8191));
                5:  f.proto = 8'h06;
                6:  f.ip_dst = f.ip_dst ^ (32'd1 << $urandom_range(0, 31));
                7:  f.udp_dst = f.udp_dst + 16'd1;
                8:  f.ip_len = f.ip_len + 16'd1;
                9:  begin f.udp_len = f.udp_len + 16'd8; f.ip_len = f.ip_len + 16'd8; end
                10: f.runt_at = int'($urandom_range(1, 6));
                default: ;
            endcase
            send_frame(f, model_fwd(f), model_lerr(f), 20);
        end
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("final_exp_q_empty", 72'(exp_q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vrlp_eth_deframer.md
# vrlp_eth_deframer

Receive-side counterpart of the VRLP Ethernet framer. It takes a 64-bit Ethernet stream from the 10GE MAC and checks the Ethernet, IPv4 and UDP headers against locally configured addresses. Matching VRLP payload is forwarded unmodified; non-matching, fragmented or runt frames are silently dropped. It sits between the MAC RX path and the VRLP demux.

## Interface
- BASE, 0: settings-bus base address; uses BASE+0..BASE+3.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush: same effect as reset on state, match flags and stats. Settings registers keep their values.
- set_stb / set_addr / set_data  in  1/8/32  settings bus:
  - BASE+0: local MAC[47:32].
  - BASE+1: local MAC[31:0].
  - BASE+2: local IP.
  - BASE+3: local UDP port [15:0].
- in_tdata / in_tuser / in_tlast / in_tvalid  in  64/4/1/1  Ethernet stream. in_tuser is the valid byte count on the last word; 0 means 8.
- in_tready  out  1
- out_tdata / out_tuser / out_tlast / out_tvalid  out  64/4/1/1  VRLP payload. out_tuser has the same meaning as in_tuser.
- out_tready  in  1
- drop_cnt  out  32  frames dropped.
- len_err_cnt  out  32  forwarded frames whose length disagreed with udp_len.

## Operation
- Word layout (big-endian within each word):
  - W1: {48'pad, dst_mac[47:32]}
  - W2: {dst_mac[31:0], src_mac[47:16]}
  - W3: {src_mac[15:0], ethertype, ver_ihl, dscp, ip_len}
  - W4: {ident, flags_frag, ttl, proto, ip_csum}
  - W5: {ip_src, ip_dst}
  - W6: {udp_src, udp_dst, udp_len, udp_csum}
  - W7 onward: payload.
- States: H1..H6, PAYLOAD, DROP. The block resets to H1.
- In H1..H6, each in_tvalid beat advances one state. A sticky `ok` flag is cleared entering H1 and ANDed with that word's checks:
  - H1: dst_mac[47:32] equals local MAC, or equals 16'hFFFF when broadcast is allowed.
  - H2: dst_mac[31:0] equals local MAC, or the broadcast value.
  - H3: ethertype==16'h0800 and ver_ihl==8'h45. Capture ip_len.
  - H4: proto==8'h11, MF bit [45]==0, frag offset [44:32]==0.
  - H5: ip_dst equals local IP.
  - H6: udp_dst equals local port, and udp_len == ip_len-20 (16-bit). Capture udp_len.
- After the H6 beat, the state goes to PAYLOAD if `ok` AND the H6 checks pass; otherwise it goes to DROP.
- Runt frame: in_tlast in any of H1..H6 means drop_cnt += 1 and return to H1.
- PAYLOAD: beats pass through combinationally. A byte counter accumulates 8 per non-last beat, plus (in_tuser==0 ? 8 : in_tuser) on the last beat. On the last beat, if the count differs from udp_len-8, len_err_cnt += 1; the frame is still forwarded. Then return to H1.
- DROP: consume beats until in_tlast, then drop_cnt += 1 and return to H1.
- Counters saturate at 32'hFFFF_FFFF.
- Broadcast dst MAC (FF:FF:FF:FF:FF:FF) is always accepted.

## Timing
- in_tready:
  - H1..H6 and DROP: 1.
  - PAYLOAD: out_tready.
- out_tvalid = in_tvalid only in PAYLOAD, else 0. out_tdata, out_tlast and out_tuser are driven from the input in PAYLOAD; out_tdata is don't-care elsewhere, and out_tlast/out_tuser are 0 outside PAYLOAD.
- Zero-cycle data latency. A header costs 6 accepted beats; there are no bubbles between frames.
- Reset values:
  - state H1, out_tvalid 0, out_tlast 0, out_tuser 0, in_tready 1.
  - counters 0.
  - settings: MAC 0, IP 0, port 0.
- A settings write mid-frame takes effect on the next compared word. Results are undefined only for the word compared in the same cycle.
- reset or clear mid-frame: return to H1 immediately. The remainder of the aborted frame is parsed as a new header and will normally be dropped.
- Counter increment in the same cycle as clear: clear wins.

## Configuration
- VRLP_ETH_DEFRAMER_STATS_EN:
  - Defined: drop_cnt, len_err_cnt and the payload byte counter are built.
  - Undefined: both counter outputs are tied to 32'd0, the byte counter is removed, and the length check is skipped. Forwarding and drop decisions are identical either way.

## Structure
- Shared package vrlp_eth_pkg:
  - state localparams
  - ETH_TYPE_IPV4=16'h0800
  - IPV4_VER_IHL=8'h45
  - IP_PROTO_UDP=8'h11
  - IP_HDR_BYTES=20, UDP_HDR_BYTES=8
  - header word count 6
- The framer imports the same package.
- Sub-module vrlp_eth_hdr_check: combinational per-state match logic (state, word, settings → pass). The top level holds the FSM, handshake and stats.

## Test plan
- Matching frame: MAC 00:80:2F:00:00:01, IP 192.168.10.2, port 49153, 5 payload words, last tuser=4 (udp_len=44, ip_len=64) → 5 words out unchanged, tuser=4 on the last, tlast aligned, both counters 0.
- Wrong udp_dst 49154, then a good frame back-to-back → first frame produces no output beats and drop_cnt=1; second frame is forwarded with no gap.
- Broadcast dst MAC; then a frame with MF=1; then ethertype 0x86DD → broadcast frame forwarded; drop_cnt=2.
- Runt: tlast on W4 → drop_cnt=1, state H1; the next good frame passes intact.
- out_tready toggling 1/0 every cycle on a 20-word payload → all words delivered in order; in_tready mirrors out_tready in PAYLOAD.
- udp_len=44 but 6 payload words with tuser=0 (48 bytes) → frame forwarded, len_err_cnt=1 (stats enabled); len_err_cnt=0 when the macro is undefined.
